// File: rtl/arb_pkg.sv
// Shared types and helpers for the priority/round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Index width that never collapses to zero for tiny N.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder: binary index, one-hot and any flag.
module prio_enc_lsb #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-input arbiter, fixed or round-robin priority, with a sticky
// valid/ready grant that is held until the consumer accepts it.
module priority_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int IDX_W   = clog2_safe(N),
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode_rr,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] rr_ptr
);

  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(RR_INIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  arb_state_e       state_q, state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]     gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic [IDX_W-1:0] ptr_after_accept;
  logic [N-1:0]     mask;
  logic [N-1:0]     req_masked;

  logic [IDX_W-1:0] msk_idx, unm_idx, win_idx;
  logic [N-1:0]     msk_oh, unm_oh, win_oh;
  logic             msk_any, unm_any;

  assign accept = (state_q == ARB_HOLD) && gnt_ready;

  // Wrap explicitly at N so non-power-of-2 sizes never reach unused indices.
  assign ptr_after_accept = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;

  assign rr_ptr_d = (accept && (mode_rr == ARB_MODE_RR)) ? ptr_after_accept : rr_ptr_q;

  // Re-arbitration on an accept edge already searches from the updated pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IDX_W'(i) >= rr_ptr_d);
    end
  end

  assign req_masked = req & mask;

  prio_enc_lsb #(.N(N), .IDX_W(IDX_W)) u_enc_masked (
    .req    (req_masked),
    .idx    (msk_idx),
    .onehot (msk_oh),
    .any    (msk_any)
  );

  prio_enc_lsb #(.N(N), .IDX_W(IDX_W)) u_enc_unmasked (
    .req    (req),
    .idx    (unm_idx),
    .onehot (unm_oh),
    .any    (unm_any)
  );

  always_comb begin
    if ((mode_rr == ARB_MODE_RR) && msk_any) begin
      win_idx = msk_idx;
      win_oh  = msk_oh;
    end else begin
      win_idx = unm_idx;
      win_oh  = unm_oh;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    case (state_q)
      ARB_IDLE: begin
        if (unm_any) begin
          state_d     = ARB_HOLD;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = win_idx;
          gnt_oh_d    = win_oh;
        end
      end
      ARB_HOLD: begin
        if (gnt_ready) begin
          if (unm_any) begin
            gnt_idx_d = win_idx;
            gnt_oh_d  = win_oh;
          end else begin
            state_d     = ARB_IDLE;
            gnt_valid_d = 1'b0;
            gnt_oh_d    = '0;
          end
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        gnt_valid_d = 1'b0;
        gnt_oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= PTR_INIT;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_oh    = gnt_oh_q;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Bench for priority_arbiter_rr: an N=8 and an N=5 instance checked every cycle
// against a circular-search reference model, plus directed literal scenarios.
module tb_priority_arbiter_rr;

  typedef struct packed {
    logic v;
    int   i;
    int   p;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0, rdy8 = 1'b0;
  logic       gv8;
  logic [2:0] gi8, gp8;
  logic [7:0] goh8;

  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0, rdy5 = 1'b0;
  logic       gv5;
  logic [2:0] gi5, gp5;
  logic [4:0] goh5;

  int n_cmp = 0;
  int n_bad = 0;

  mstate_t m8 = '{v: 1'b0, i: 0, p: 0};
  mstate_t m5 = '{v: 1'b0, i: 0, p: 3};

  always #5 clk = ~clk;

  priority_arbiter_rr #(.N(8), .RR_INIT(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode_rr(mode8), .gnt_ready(rdy8),
    .gnt_valid(gv8), .gnt_idx(gi8), .gnt_oh(goh8), .rr_ptr(gp8)
  );

  priority_arbiter_rr #(.N(5), .RR_INIT(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode_rr(mode5), .gnt_ready(rdy5),
    .gnt_valid(gv5), .gnt_idx(gi5), .gnt_oh(goh5), .rr_ptr(gp5)
  );

  // Winner of one arbitration: walk the requesters in priority order.
  function automatic int arb(input logic [63:0] r, input int n, input int p, input logic rr);
    for (int k = 0; k < n; k++) begin
      int i;
      i = rr ? (p + k) % n : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [63:0] r,
                                         input logic rr, input logic rdy, input int n);
    mstate_t t;
    int w;
    t = s;
    if (!s.v) begin
      w = arb(r, n, s.p, rr);
      if (w >= 0) begin
        t.v = 1'b1;
        t.i = w;
      end
    end else if (rdy) begin
      if (rr) t.p = (s.i + 1) % n;
      w = arb(r, n, t.p, rr);
      if (w >= 0) t.i = w;
      else t.v = 1'b0;
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '{v: 1'b0, i: 0, p: 0};
      m5 <= '{v: 1'b0, i: 0, p: 3};
    end else begin
      m8 <= model_next(m8, 64'(req8), mode8, rdy8, 8);
      m5 <= model_next(m5, 64'(req5), mode5, rdy5, 5);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model comparison on every falling edge, away from the registered updates.
  always @(negedge clk) begin
    chk("m8_valid", 64'(gv8), 64'(m8.v));
    chk("m8_idx",   64'(gi8), 64'(m8.i));
    chk("m8_oh",    64'(goh8), m8.v ? (64'd1 << m8.i) : 64'd0);
    chk("m8_ptr",   64'(gp8), 64'(m8.p));
    chk("m5_valid", 64'(gv5), 64'(m5.v));
    chk("m5_idx",   64'(gi5), 64'(m5.i));
    chk("m5_oh",    64'(goh5), m5.v ? (64'd1 << m5.i) : 64'd0);
    chk("m5_ptr",   64'(gp5), 64'(m5.p));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic exp8(input string nm, input logic v, input int i, input logic [7:0] oh, input int p);
    chk({nm, "_valid"}, 64'(gv8), 64'(v));
    chk({nm, "_idx"},   64'(gi8), 64'(i));
    chk({nm, "_oh"},    64'(goh8), 64'(oh));
    chk({nm, "_ptr"},   64'(gp8), 64'(p));
  endtask

  initial begin
    int seq5[4];
    int ptr5[4];
    logic [31:0] r;
    seq5 = '{4, 0, 4, 0};
    ptr5 = '{3, 0, 1, 0};

    repeat (2) cyc();
    exp8("reset8", 1'b0, 0, 8'h00, 0);
    chk("reset5_ptr", 64'(gp5), 64'd3);
    rst_n = 1'b1;

    // Fixed priority: 5 then 7 then idle with idx held.
    mode8 = 1'b0; rdy8 = 1'b1; req8 = 8'b1010_0000;
    cyc(); exp8("fix_a", 1'b1, 5, 8'h20, 0);
    req8 = 8'h80;
    cyc(); exp8("fix_b", 1'b1, 7, 8'h80, 0);
    req8 = 8'h00;
    cyc(); exp8("fix_c", 1'b0, 7, 8'h00, 0);

    // Round-robin sweep with everyone requesting.
    mode8 = 1'b1; req8 = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      cyc(); exp8("rr_sweep", 1'b1, k % 8, 8'(1 << (k % 8)), k % 8);
    end
    req8 = 8'h00;
    cyc(); exp8("rr_end", 1'b0, 0, 8'h00, 1);

    // Backpressure: grant is sticky even after its request drops.
    mode8 = 1'b0; rdy8 = 1'b0; req8 = 8'h0C;
    cyc(); exp8("bp_grant", 1'b1, 2, 8'h04, 1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req8 = 8'h00;
      cyc(); exp8("bp_hold", 1'b1, 2, 8'h04, 1);
    end
    rdy8 = 1'b1;
    cyc(); exp8("bp_accept", 1'b0, 2, 8'h00, 1);

    // Steer rr_ptr to 3, then switch mode mid-hold.
    mode8 = 1'b1; req8 = 8'h04;
    cyc(); exp8("ms_pre", 1'b1, 2, 8'h04, 1);
    req8 = 8'h00;
    cyc(); exp8("ms_idle", 1'b0, 2, 8'h00, 3);
    rdy8 = 1'b0; req8 = 8'h09;
    cyc(); exp8("ms_grant", 1'b1, 3, 8'h08, 3);
    mode8 = 1'b0;
    cyc(); exp8("ms_held", 1'b1, 3, 8'h08, 3);
    rdy8 = 1'b1;
    cyc(); exp8("ms_fixed", 1'b1, 0, 8'h01, 3);
    req8 = 8'h00;
    cyc(); exp8("ms_done", 1'b0, 0, 8'h00, 3);

    // N=5 round-robin wraps at 5, not 8.
    mode5 = 1'b1; rdy5 = 1'b1; req5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("n5_idx", 64'(gi5), 64'(seq5[k]));
      chk("n5_ptr", 64'(gp5), 64'(ptr5[k]));
    end
    req5 = 5'b00000;
    cyc(); chk("n5_idle", 64'(gv5), 64'd0);

    // Asynchronous reset while a grant is held.
    mode8 = 1'b1; rdy8 = 1'b0; req8 = 8'hFF;
    cyc(); exp8("rst_pre", 1'b1, 3, 8'h08, 3);
    #2 rst_n = 1'b0;
    #1;
    exp8("rst_async", 1'b0, 0, 8'h00, 0);
    chk("rst_async5_ptr", 64'(gp5), 64'd3);
    cyc(); cyc();
    rst_n = 1'b1; rdy8 = 1'b1;
    cyc(); exp8("rst_after", 1'b1, 0, 8'h01, 0);

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = r & $urandom;
      if ($urandom_range(0, 7) == 0) r = '0;
      req8 = r[7:0];
      req5 = r[12:8];
      rdy8 = ($urandom_range(0, 2) != 0);
      rdy5 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mode8 = ~mode8;
      if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
